// File: rtl/tcm_mem_pipe.sv
// tcm_mem_pipe: dual-port 64-bit TCM with a 64-bit fetch port and a
// 32-bit byte-writable data port, range checks and 1/2-cycle latency.
// Ports: clk_i, rst_ni; mem_i_* fetch port (pc in, inst/valid/error out);
// mem_d_* data port (addr/data/rd/wr/tag in, ack/error/data/tag out).
module tcm_mem_pipe #(
    parameter int          MEM_ADDR_W  = 14,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          PIPE_STAGES = 1,
    parameter int          TAG_W       = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mem_i_rd_i,
    input  logic             mem_i_flush_i,
    input  logic             mem_i_invalidate_i,
    input  logic [31:0]      mem_i_pc_i,
    output logic             mem_i_accept_o,
    output logic             mem_i_valid_o,
    output logic             mem_i_error_o,
    output logic [63:0]      mem_i_inst_o,
    input  logic [31:0]      mem_d_addr_i,
    input  logic [31:0]      mem_d_data_wr_i,
    input  logic             mem_d_rd_i,
    input  logic [3:0]       mem_d_wr_i,
    input  logic             mem_d_cacheable_i,
    input  logic [TAG_W-1:0] mem_d_req_tag_i,
    input  logic             mem_d_invalidate_i,
    input  logic             mem_d_writeback_i,
    input  logic             mem_d_flush_i,
    output logic             mem_d_accept_o,
    output logic             mem_d_ack_o,
    output logic             mem_d_error_o,
    output logic [31:0]      mem_d_data_rd_o,
    output logic [TAG_W-1:0] mem_d_resp_tag_o
);
    localparam int DEPTH = 1 << MEM_ADDR_W;
    localparam int OFF_W = MEM_ADDR_W + 3;

    logic [63:0] ram [DEPTH];

    logic [31:0]           d_off;
    logic [31:0]           i_off;
    logic                  d_in;
    logic                  i_in;
    logic [MEM_ADDR_W-1:0] d_idx;
    logic [MEM_ADDR_W-1:0] i_idx;
    logic                  d_wr;
    logic                  d_rd;
    logic                  d_req;
    logic                  d_we;
    logic                  fwd_hit;
    logic [7:0]            be;
    logic [63:0]           wd;
    logic [63:0]           i_fwd;

    // Offset from the window base; anything past the capacity,
    // including addresses below the base (wrap), is out of range.
    assign d_off   = mem_d_addr_i - BASE_ADDR;
    assign i_off   = mem_i_pc_i - BASE_ADDR;
    assign d_in    = (d_off >> OFF_W) == 32'd0;
    assign i_in    = (i_off >> OFF_W) == 32'd0;
    assign d_idx   = d_off[OFF_W-1:3];
    assign i_idx   = i_off[OFF_W-1:3];

    // rd together with wr counts as a write and returns no data
    assign d_wr    = |mem_d_wr_i;
    assign d_rd    = mem_d_rd_i & ~d_wr;
    assign d_req   = mem_d_rd_i | d_wr | mem_d_flush_i
                   | mem_d_invalidate_i | mem_d_writeback_i;
    assign d_we    = rst_ni & d_wr & d_in;
    assign be      = d_off[2] ? {mem_d_wr_i, 4'b0000}
                              : {4'b0000, mem_d_wr_i};
    assign wd      = {mem_d_data_wr_i, mem_d_data_wr_i};
    assign fwd_hit = d_we & (d_idx == i_idx);

    always_ff @(posedge clk_i) begin
        if (d_we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) ram[d_idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    // Fetch sees the post-write word when it hits the word being written
    always_comb begin
        i_fwd = ram[i_idx];
        for (int b = 0; b < 8; b++) begin
            if (fwd_hit && be[b]) i_fwd[8*b +: 8] = wd[8*b +: 8];
        end
    end

    logic             i_v1;
    logic             i_err1;
    logic [63:0]      i_word1;
    logic             d_v1;
    logic [TAG_W-1:0] d_tag1;
    logic             d_hi1;
    logic             d_err1;
    logic             d_nd1;
    logic [63:0]      d_word1;

    // Payload registers only load on a live response so the outputs
    // hold their value until the next one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_v1    <= 1'b0;
            i_err1  <= 1'b0;
            i_word1 <= 64'd0;
            d_v1    <= 1'b0;
            d_tag1  <= '0;
            d_hi1   <= 1'b0;
            d_err1  <= 1'b0;
            d_nd1   <= 1'b0;
            d_word1 <= 64'd0;
        end else begin
            i_v1 <= mem_i_rd_i & ~mem_i_flush_i;
            if (mem_i_rd_i && !mem_i_flush_i) begin
                i_err1  <= ~i_in;
                i_word1 <= i_in ? i_fwd : 64'd0;
            end
            d_v1 <= d_req;
            if (d_req) begin
                d_tag1 <= mem_d_req_tag_i;
                d_hi1  <= d_off[2];
                d_err1 <= ~d_in;
                d_nd1  <= ~(d_rd & d_in);
            end
            if (d_rd && d_in) d_word1 <= ram[d_idx];
        end
    end

    logic             i_vq;
    logic             i_errq;
    logic [63:0]      i_wordq;
    logic             d_vq;
    logic [TAG_W-1:0] d_tagq;
    logic             d_hiq;
    logic             d_errq;
    logic             d_ndq;
    logic [63:0]      d_wordq;

    generate
        if (PIPE_STAGES == 2) begin : g_pipe2
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    i_vq    <= 1'b0;
                    i_errq  <= 1'b0;
                    i_wordq <= 64'd0;
                    d_vq    <= 1'b0;
                    d_tagq  <= '0;
                    d_hiq   <= 1'b0;
                    d_errq  <= 1'b0;
                    d_ndq   <= 1'b0;
                    d_wordq <= 64'd0;
                end else begin
                    i_vq <= i_v1 & ~mem_i_flush_i;
                    if (i_v1 && !mem_i_flush_i) begin
                        i_errq  <= i_err1;
                        i_wordq <= i_word1;
                    end
                    d_vq <= d_v1;
                    if (d_v1) begin
                        d_tagq <= d_tag1;
                        d_hiq  <= d_hi1;
                        d_errq <= d_err1;
                        d_ndq  <= d_nd1;
                    end
                    if (d_v1 && !d_nd1) d_wordq <= d_word1;
                end
            end
        end else begin : g_pipe1
            assign i_vq    = i_v1;
            assign i_errq  = i_err1;
            assign i_wordq = i_word1;
            assign d_vq    = d_v1;
            assign d_tagq  = d_tag1;
            assign d_hiq   = d_hi1;
            assign d_errq  = d_err1;
            assign d_ndq   = d_nd1;
            assign d_wordq = d_word1;
        end
    endgenerate

    assign mem_i_accept_o   = 1'b1;
    assign mem_i_valid_o    = i_vq;
    assign mem_i_error_o    = i_errq;
    assign mem_i_inst_o     = i_wordq;
    assign mem_d_accept_o   = 1'b1;
    assign mem_d_ack_o      = d_vq;
    assign mem_d_error_o    = d_errq;
    assign mem_d_resp_tag_o = d_tagq;
    assign mem_d_data_rd_o  = d_ndq ? 32'd0
                            : d_hiq ? d_wordq[63:32] : d_wordq[31:0];

    logic unused_ok;
    assign unused_ok = ^{mem_i_invalidate_i, mem_d_cacheable_i};

endmodule

// File: tb/tb_tcm_mem_pipe.sv
// tb_tcm_mem_pipe: scoreboard bench driving one 1-stage and one 2-stage
// tcm_mem_pipe with identical stimulus against a word-level memory model.
module tb_tcm_mem_pipe;
    localparam int          AW   = 8;
    localparam int          TW   = 11;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] CAP  = 32'd8 << AW;

    typedef struct {
        int            cyc;
        logic [TW-1:0] tag;
        logic          err;
        logic [63:0]   data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          i_rd;
    logic          i_flush;
    logic [31:0]   i_pc;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_rd;
    logic [3:0]    d_wr;
    logic          d_flush;
    logic          d_inv;
    logic          d_wb;
    logic [TW-1:0] d_tag;

    logic          p1_i_acc, p1_i_valid, p1_i_err;
    logic [63:0]   p1_i_inst;
    logic          p1_d_acc, p1_d_ack, p1_d_err;
    logic [31:0]   p1_d_data;
    logic [TW-1:0] p1_d_tag;
    logic          p2_i_acc, p2_i_valid, p2_i_err;
    logic [63:0]   p2_i_inst;
    logic          p2_d_acc, p2_d_ack, p2_d_err;
    logic [31:0]   p2_d_data;
    logic [TW-1:0] p2_d_tag;

    int   cyc;
    int   n_chk;
    int   n_err;
    exp_t dq1[$];
    exp_t dq2[$];
    exp_t fq1[$];
    exp_t fq2[$];
    logic [63:0] mdl [1 << AW];

    tcm_mem_pipe #(
        .MEM_ADDR_W(AW), .BASE_ADDR(BASE), .PIPE_STAGES(1), .TAG_W(TW)
    ) u_p1 (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush),
        .mem_i_invalidate_i(1'b0), .mem_i_pc_i(i_pc),
        .mem_i_accept_o(p1_i_acc), .mem_i_valid_o(p1_i_valid),
        .mem_i_error_o(p1_i_err), .mem_i_inst_o(p1_i_inst),
        .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata),
        .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr),
        .mem_d_cacheable_i(1'b1), .mem_d_req_tag_i(d_tag),
        .mem_d_invalidate_i(d_inv), .mem_d_writeback_i(d_wb),
        .mem_d_flush_i(d_flush), .mem_d_accept_o(p1_d_acc),
        .mem_d_ack_o(p1_d_ack), .mem_d_error_o(p1_d_err),
        .mem_d_data_rd_o(p1_d_data), .mem_d_resp_tag_o(p1_d_tag)
    );

    tcm_mem_pipe #(
        .MEM_ADDR_W(AW), .BASE_ADDR(BASE), .PIPE_STAGES(2), .TAG_W(TW)
    ) u_p2 (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush),
        .mem_i_invalidate_i(1'b0), .mem_i_pc_i(i_pc),
        .mem_i_accept_o(p2_i_acc), .mem_i_valid_o(p2_i_valid),
        .mem_i_error_o(p2_i_err), .mem_i_inst_o(p2_i_inst),
        .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata),
        .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr),
        .mem_d_cacheable_i(1'b1), .mem_d_req_tag_i(d_tag),
        .mem_d_invalidate_i(d_inv), .mem_d_writeback_i(d_wb),
        .mem_d_flush_i(d_flush), .mem_d_accept_o(p2_d_acc),
        .mem_d_ack_o(p2_d_ack), .mem_d_error_o(p2_d_err),
        .mem_d_data_rd_o(p2_d_data), .mem_d_resp_tag_o(p2_d_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic err,
                       input logic [63:0] data, input logic [TW-1:0] tg,
                       input logic has_tag);
        chk({nm, " cyc"}, 64'(cyc), 64'(e.cyc));
        if (has_tag) chk({nm, " tag"}, 64'(tg), 64'(e.tag));
        chk({nm, " err"}, 64'(err), 64'(e.err));
        chk({nm, " data"}, data, e.data);
    endtask

    always @(negedge clk) begin
        if (p1_d_ack) begin
            if (dq1.size() == 0) chk("p1 d spurious", 64'(p1_d_ack), 64'd0);
            else begin
                cmp("p1 d", dq1[0], p1_d_err, {32'd0, p1_d_data}, p1_d_tag, 1'b1);
                dq1.delete(0);
            end
        end else if (dq1.size() != 0 && dq1[0].cyc <= cyc) begin
            chk("p1 d missing ack", 64'(p1_d_ack), 64'd1);
            dq1.delete(0);
        end
        if (p1_i_valid) begin
            if (fq1.size() == 0) chk("p1 i spurious", 64'(p1_i_valid), 64'd0);
            else begin
                cmp("p1 i", fq1[0], p1_i_err, p1_i_inst, '0, 1'b0);
                fq1.delete(0);
            end
        end else if (fq1.size() != 0 && fq1[0].cyc <= cyc) begin
            chk("p1 i missing valid", 64'(p1_i_valid), 64'd1);
            fq1.delete(0);
        end
    end

    always @(negedge clk) begin
        if (p2_d_ack) begin
            if (dq2.size() == 0) chk("p2 d spurious", 64'(p2_d_ack), 64'd0);
            else begin
                cmp("p2 d", dq2[0], p2_d_err, {32'd0, p2_d_data}, p2_d_tag, 1'b1);
                dq2.delete(0);
            end
        end else if (dq2.size() != 0 && dq2[0].cyc <= cyc) begin
            chk("p2 d missing ack", 64'(p2_d_ack), 64'd1);
            dq2.delete(0);
        end
        if (p2_i_valid) begin
            if (fq2.size() == 0) chk("p2 i spurious", 64'(p2_i_valid), 64'd0);
            else begin
                cmp("p2 i", fq2[0], p2_i_err, p2_i_inst, '0, 1'b0);
                fq2.delete(0);
            end
        end else if (fq2.size() != 0 && fq2[0].cyc <= cyc) begin
            chk("p2 i missing valid", 64'(p2_i_valid), 64'd1);
            fq2.delete(0);
        end
    end

    task automatic drive(input logic ird, input logic [31:0] pc,
                         input logic ifl, input logic drd,
                         input logic [3:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdat, input logic [2:0] mnt,
                         input logic [TW-1:0] tag);
        logic [31:0] doff;
        logic [31:0] ioff;
        logic        din;
        logic        iin;
        logic [AW-1:0] didx;
        logic [AW-1:0] iidx;
        logic [63:0] nw;
        logic [63:0] w;
        exp_t        e;
        i_rd = ird; i_pc = pc; i_flush = ifl;
        d_rd = drd; d_wr = wr; d_addr = addr; d_wdata = wdat;
        {d_wb, d_inv, d_flush} = mnt; d_tag = tag;
        doff = addr - BASE;
        ioff = pc - BASE;
        din  = doff < CAP;
        iin  = ioff < CAP;
        didx = doff[AW+2:3];
        iidx = ioff[AW+2:3];
        nw = mdl[didx];
        for (int k = 0; k < 4; k++) begin
            if (wr[k]) nw[(doff[2] ? 32 : 0) + 8*k +: 8] = wdat[8*k +: 8];
        end
        if (drd || wr != 4'd0 || mnt != 3'd0) begin
            e.tag = tag;
            e.err = !din;
            e.data = 64'd0;
            if (din && drd && wr == 4'd0)
                e.data = doff[2] ? {32'd0, mdl[didx][63:32]}
                                 : {32'd0, mdl[didx][31:0]};
            e.cyc = cyc + 1; dq1.push_back(e);
            e.cyc = cyc + 2; dq2.push_back(e);
        end
        w = (din && wr != 4'd0 && didx == iidx) ? nw : mdl[iidx];
        if (ifl) begin
            for (int k = fq1.size() - 1; k >= 0; k--)
                if (fq1[k].cyc > cyc) fq1.delete(k);
            for (int k = fq2.size() - 1; k >= 0; k--)
                if (fq2[k].cyc > cyc) fq2.delete(k);
        end
        if (ird && !ifl) begin
            e.tag = '0;
            e.err = !iin;
            e.data = iin ? w : 64'd0;
            e.cyc = cyc + 1; fq1.push_back(e);
            e.cyc = cyc + 2; fq2.push_back(e);
        end
        if (din && wr != 4'd0) mdl[didx] = nw;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, BASE, 1'b0, 1'b0, 4'd0, BASE, 32'd0, 3'd0, '0);
    endtask

    task automatic rst_cycle();
        i_rd = 1'b1; i_pc = BASE + 32'($urandom_range(0, 3) * 8);
        i_flush = 1'b0; d_rd = 1'b1; d_wr = 4'hF;
        d_addr = BASE + 32'($urandom_range(0, 7) * 4);
        d_wdata = $urandom; {d_wb, d_inv, d_flush} = 3'b001;
        d_tag = TW'($urandom);
        @(posedge clk);
        #1;
        chk("p1 rst inst", p1_i_inst, 64'd0);
        chk("p1 rst ctl", 64'({p1_i_valid, p1_i_err, p1_d_ack, p1_d_err,
                              p1_d_tag, p1_d_data}), 64'd0);
        chk("p2 rst inst", p2_i_inst, 64'd0);
        chk("p2 rst ctl", 64'({p2_i_valid, p2_i_err, p2_d_ack, p2_d_err,
                              p2_d_tag, p2_d_data}), 64'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int k = 0; k < (1 << AW); k++) mdl[k] = 64'd0;
        for (int k = 0; k < 4; k++) rst_cycle();
        rst_n = 1'b1;
        chk("accept", 64'({p1_i_acc, p1_d_acc, p2_i_acc, p2_d_acc}), 64'hF);

        for (int k = 0; k < (2 << AW); k++)
            drive(1'b0, BASE, 1'b0, 1'b0, 4'hF, BASE + 32'(4 * k),
                  32'd0, 3'd0, k[TW-1:0]);

        drive(1'b0, BASE, 1'b0, 1'b0, 4'hF, BASE + 32'h4, 32'hDEADBEEF, 3'd0, 11'd1);
        drive(1'b0, BASE, 1'b0, 1'b0, 4'h2, BASE, 32'h0000AA00, 3'd0, 11'd2);
        drive(1'b1, BASE, 1'b0, 1'b1, 4'h0, BASE + 32'h4, 32'd0, 3'd0, 11'd3);
        drive(1'b0, BASE, 1'b0, 1'b1, 4'h0, BASE, 32'd0, 3'd0, 11'd4);

        drive(1'b0, BASE, 1'b0, 1'b0, 4'hF, BASE + CAP, 32'hFFFFFFFF, 3'd0, 11'd5);
        drive(1'b1, BASE - 32'd8, 1'b0, 1'b1, 4'h0, BASE, 32'd0, 3'd0, 11'd6);
        drive(1'b1, BASE + CAP - 32'd8, 1'b0, 1'b1, 4'h0, BASE + CAP - 32'd4,
              32'd0, 3'd0, 11'd7);
        drive(1'b1, BASE + CAP, 1'b0, 1'b1, 4'h0, BASE + CAP + 32'd4,
              32'd0, 3'd0, 11'd8);

        drive(1'b1, BASE + 32'h10, 1'b0, 1'b0, 4'hF, BASE + 32'h14,
              32'h12345678, 3'd0, 11'd9);
        drive(1'b1, BASE + 32'h10, 1'b0, 1'b1, 4'h0, BASE + 32'h14,
              32'd0, 3'd0, 11'd10);
        idle(3);

        drive(1'b1, BASE, 1'b0, 1'b0, 4'h0, BASE, 32'd0, 3'd0, '0);
        drive(1'b1, BASE + 32'h8, 1'b0, 1'b0, 4'h0, BASE, 32'd0, 3'd0, '0);
        drive(1'b1, BASE + 32'h10, 1'b1, 1'b0, 4'h0, BASE, 32'd0, 3'd0, '0);
        drive(1'b1, BASE + 32'h18, 1'b0, 1'b0, 4'h0, BASE, 32'd0, 3'd0, '0);
        idle(3);

        for (int k = 0; k < 8; k++)
            drive(1'b0, BASE, 1'b0, (k % 3) == 0, (k % 3) == 1 ? 4'hC : 4'h0,
                  BASE + 32'(4 * k), 32'hA5A50000 + 32'(k),
                  (k % 3) == 2 ? 3'd1 : 3'd0, k[TW-1:0]);
        idle(3);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [31:0] pc;
            logic [3:0]  wr;
            logic        rd;
            logic [2:0]  mnt;
            int          op;
            op  = int'($urandom_range(0, 9));
            a   = BASE + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 15) == 0)
                a = ($urandom_range(0, 1) == 1)
                    ? BASE + CAP + 32'($urandom_range(0, 7) * 4)
                    : BASE - 32'd4;
            pc  = BASE + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) pc = BASE + CAP;
            wr  = 4'($urandom_range(1, 15));
            rd  = 1'b0;
            mnt = 3'd0;
            if (op < 4) begin
                rd = 1'b1; wr = 4'd0;
            end else if (op == 7) begin
                mnt = 3'(1 << $urandom_range(0, 2)); wr = 4'd0;
            end else if (op == 8) begin
                rd = 1'b1;
            end else if (op == 9) begin
                wr = 4'd0;
            end
            drive($urandom_range(0, 1) == 1, pc, $urandom_range(0, 19) == 0,
                  rd, wr, a, $urandom, mnt, n[TW-1:0]);
        end

        drive(1'b1, BASE, 1'b0, 1'b1, 4'h0, BASE, 32'd0, 3'd0, 11'd1);
        drive(1'b1, BASE + 32'h8, 1'b0, 1'b0, 4'hF, BASE + 32'h8,
              32'h55, 3'd0, 11'd2);
        rst_n = 1'b0;
        dq1.delete(); dq2.delete(); fq1.delete(); fq2.delete();
        #1;
        chk("p1 async rst", 64'({p1_i_valid, p1_i_err, p1_d_ack, p1_d_err,
                                 p1_d_tag, p1_d_data}), 64'd0);
        chk("p2 async rst", 64'({p2_i_valid, p2_i_err, p2_d_ack, p2_d_err,
                                 p2_d_tag, p2_d_data}), 64'd0);
        chk("p1 async rst inst", p1_i_inst, 64'd0);
        chk("p2 async rst inst", p2_i_inst, 64'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++)
            drive(k < 4, BASE + 32'(8 * k), 1'b0, 1'b1, 4'h0,
                  BASE + 32'(4 * k), 32'd0, 3'd0, k[TW-1:0]);
        idle(4);

        chk("p1 dq drain", 64'(dq1.size()), 64'd0);
        chk("p2 dq drain", 64'(dq2.size()), 64'd0);
        chk("p1 fq drain", 64'(fq1.size()), 64'd0);
        chk("p2 fq drain", 64'(fq2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
